// File: rtl/crc32_pkg.sv
// Shared constants, FSM state type and byte-serial update for the reflected CRC-32
// used by the receive-side frame checker.
package crc32_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_XOROUT  = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } state_t;

    // One byte through the right-shifting LFSR, LSB of the byte first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_rx_checker_if.sv
// Word stream from the deframer into the frame checker: three bytes per beat,
// with a byte count qualifying the final beat.
interface crc32_rx_checker_if;

    logic        s_valid_i;
    logic        s_ready_o;
    logic [23:0] s_data_i;
    logic        s_last_i;
    logic [1:0]  s_nbytes_i;

    modport master (
        output s_valid_i, s_data_i, s_last_i, s_nbytes_i,
        input  s_ready_o
    );

    modport slave (
        input  s_valid_i, s_data_i, s_last_i, s_nbytes_i,
        output s_ready_o
    );

endinterface

// File: rtl/crc32_upd8.sv
// Combinational single-byte CRC-32 step; three of these chained give the
// 8/16/24-bit updates for one word.
module crc32_upd8
    import crc32_pkg::*;
(
    input  logic [31:0] crc_cur,
    input  logic [7:0]  data,
    output logic [31:0] crc_nxt
);

    assign crc_nxt = crc32_byte(crc_cur, data);

endmodule

// File: rtl/crc32_rx_checker.sv
// Receive-side FCS check: runs CRC-32 over frame bytes plus the appended FCS,
// compares against the residue and reports status, length and frame counters.
module crc32_rx_checker
    import crc32_pkg::*;
#(
    parameter int LEN_W   = 16,
    parameter int CNT_W   = 16,
    parameter int MIN_LEN = 4
)
(
    input  logic               clk_i,
    input  logic               rst_ni,
    crc32_rx_checker_if.slave  s,
    input  logic               clear_cnt_i,
    output logic               done_o,
    output logic               crc_ok_o,
    output logic               runt_o,
    output logic [31:0]        crc_o,
    output logic [LEN_W-1:0]   len_o,
    output logic [CNT_W-1:0]   good_cnt_o,
    output logic [CNT_W-1:0]   bad_cnt_o
);

    state_t             state_q, state_d;
    logic [31:0]        crc_q;
    logic [31:0]        tap1, tap2, tap3;
    logic [31:0]        crc_nxt;
    logic [LEN_W-1:0]   cnt_q, cnt_nxt;
    logic [LEN_W:0]     cnt_sum;
    logic [1:0]         n_bytes;
    logic               ready;
    logic               accept;
    logic               last_accept;
    logic               runt_nxt;

    logic               ok_q, runt_q;
    logic [31:0]        crc_res_q;
    logic [LEN_W-1:0]   len_q;
    logic [CNT_W-1:0]   good_q, bad_q;

    // Low lane is first on the wire, so it enters the chain first.
    crc32_upd8 u_lane0 (.crc_cur(crc_q), .data(s.s_data_i[7:0]),   .crc_nxt(tap1));
    crc32_upd8 u_lane1 (.crc_cur(tap1),  .data(s.s_data_i[15:8]),  .crc_nxt(tap2));
    crc32_upd8 u_lane2 (.crc_cur(tap2),  .data(s.s_data_i[23:16]), .crc_nxt(tap3));

    assign ready       = (state_q != REPORT);
    assign s.s_ready_o = ready;
    assign accept      = s.s_valid_i & ready;
    assign last_accept = accept & s.s_last_i;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        n_bytes = 2'd3;
        if (s.s_last_i && (s.s_nbytes_i != 2'd0)) begin
            n_bytes = s.s_nbytes_i;
        end

        crc_nxt = tap3;
        if (n_bytes == 2'd1) begin
            crc_nxt = tap1;
        end else if (n_bytes == 2'd2) begin
            crc_nxt = tap2;
        end

        cnt_sum  = {1'b0, cnt_q} + (LEN_W+1)'(n_bytes);
        cnt_nxt  = cnt_sum[LEN_W] ? '1 : cnt_sum[LEN_W-1:0];
        runt_nxt = (cnt_nxt < LEN_W'(MIN_LEN));
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, RUN: begin
                if (accept) begin
                    state_d = s.s_last_i ? REPORT : RUN;
                end
            end
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            crc_q   <= CRC32_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == REPORT) begin
                crc_q <= CRC32_INIT;
                cnt_q <= '0;
            end else if (accept) begin
                crc_q <= crc_nxt;
                cnt_q <= cnt_nxt;
            end
        end
    end

    // Results are captured as the last word lands so they are already valid in
    // the REPORT cycle and simply hold afterwards.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ok_q      <= 1'b0;
            runt_q    <= 1'b0;
            crc_res_q <= '0;
            len_q     <= '0;
        end else if (last_accept) begin
            ok_q      <= (crc_nxt == CRC32_RESIDUE) && !runt_nxt;
            runt_q    <= runt_nxt;
            crc_res_q <= crc_nxt ^ CRC32_XOROUT;
            len_q     <= cnt_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            good_q <= '0;
            bad_q  <= '0;
        end else if (clear_cnt_i) begin
            good_q <= '0;
            bad_q  <= '0;
        end else if (state_q == REPORT) begin
            if (ok_q) begin
                if (good_q != '1) good_q <= good_q + CNT_W'(1);
            end else begin
                if (bad_q != '1) bad_q <= bad_q + CNT_W'(1);
            end
        end
    end

    assign done_o     = (state_q == REPORT);
    assign crc_ok_o   = ok_q;
    assign runt_o     = runt_q;
    assign crc_o      = crc_res_q;
    assign len_o      = len_q;
    assign good_cnt_o = good_q;
    assign bad_cnt_o  = bad_q;

endmodule

// File: tb/tb_crc32_rx_checker.sv
// Self-checking bench for crc32_rx_checker: directed vectors plus random frames
// against a bit-serial frame-level CRC model.
module tb_crc32_rx_checker;

    localparam logic [31:0] POLY    = 32'hEDB8_8320;
    localparam logic [31:0] RESIDUE = 32'hDEBB_20E3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear_cnt = 1'b0;
    logic        done, crc_ok, runt;
    logic [31:0] crc;
    logic [15:0] len, good_cnt, bad_cnt;

    crc32_rx_checker_if bus ();

    crc32_rx_checker #(.LEN_W(16), .CNT_W(16), .MIN_LEN(4)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .s          (bus),
        .clear_cnt_i(clear_cnt),
        .done_o     (done),
        .crc_ok_o   (crc_ok),
        .runt_o     (runt),
        .crc_o      (crc),
        .len_o      (len),
        .good_cnt_o (good_cnt),
        .bad_cnt_o  (bad_cnt)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  frame_q[$];
    logic [15:0] good_m = '0;
    logic [15:0] bad_m = '0;
    bit          in_report = 1'b0;

    // CRC register after the whole frame, one input bit at a time.
    function automatic logic [31:0] model_reg();
        logic [31:0] r;
        bit fb;
        r = 32'hFFFF_FFFF;
        foreach (frame_q[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = r[0] ^ frame_q[i][b];
                r  = r >> 1;
                if (fb) r = r ^ POLY;
            end
        end
        return r;
    endfunction

    task automatic append_fcs();
        logic [31:0] f;
        f = ~model_reg();
        for (int k = 0; k < 4; k++) frame_q.push_back(f[8*k +: 8]);
    endtask

    task automatic random_payload(input int n);
        frame_q.delete();
        for (int i = 0; i < n; i++) frame_q.push_back(8'($urandom()));
    endtask

    // Starts and ends at a falling edge. hold keeps valid high into the next frame.
    task automatic send_frame(input bit hold, input bit clr, input bit gaps);
        int          n, idx, take, stalls, exp_stalls, guard, early_done;
        bit          last;
        logic [23:0] w;
        logic [31:0] reg_m;
        bit          exp_ok;
        n          = frame_q.size();
        idx        = 0;
        stalls     = 0;
        early_done = 0;
        exp_stalls = in_report ? 1 : 0;
        reg_m      = model_reg();
        exp_ok     = (reg_m == RESIDUE) && (n >= 4);
        while (idx < n) begin
            last = (n - idx) <= 3;
            take = last ? (n - idx) : 3;
            w = 24'($urandom());
            for (int k = 0; k < take; k++) w[8*k +: 8] = frame_q[idx+k];
            if (gaps && !in_report && $urandom_range(0, 3) == 0) begin
                bus.s_valid_i = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge clk);
            end
            bus.s_valid_i  = 1'b1;
            bus.s_data_i   = w;
            bus.s_last_i   = last;
            bus.s_nbytes_i = last ? (((take == 3) && ($urandom_range(0, 1) == 1)) ? 2'd0 : 2'(take))
                                  : 2'($urandom_range(0, 3));
            guard = 0;
            while (!bus.s_ready_o && guard < 8) begin
                stalls++;
                guard++;
                @(negedge clk);
            end
            @(posedge clk);
            @(negedge clk);
            in_report = 1'b0;
            idx += take;
            if (!last && done !== 1'b0) early_done++;
        end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL done_pulse got=%b exp=1 len=%0d", done, n); end
        checks++; if (early_done != 0) begin failures++; $display("FAIL done_early got=%0d exp=0", early_done); end
        checks++; if (bus.s_ready_o !== 1'b0) begin failures++; $display("FAIL ready_report got=%b exp=0", bus.s_ready_o); end
        checks++; if (stalls != exp_stalls) begin failures++; $display("FAIL stall_cycles got=%0d exp=%0d", stalls, exp_stalls); end
        checks++; if (crc_ok !== exp_ok) begin failures++; $display("FAIL crc_ok got=%b exp=%b len=%0d", crc_ok, exp_ok, n); end
        checks++; if (runt !== (n < 4)) begin failures++; $display("FAIL runt got=%b exp=%b", runt, (n < 4)); end
        checks++; if (crc !== ~reg_m) begin failures++; $display("FAIL crc_out got=%h exp=%h", crc, ~reg_m); end
        checks++; if (len !== 16'(n)) begin failures++; $display("FAIL len got=%0d exp=%0d", len, n); end
        in_report = 1'b1;
        if (exp_ok) begin
            if (good_m != 16'hFFFF) good_m++;
        end else begin
            if (bad_m != 16'hFFFF) bad_m++;
        end
        if (!hold) begin
            bus.s_valid_i = 1'b0;
            clear_cnt     = clr;
            @(negedge clk);
            clear_cnt = 1'b0;
            in_report = 1'b0;
            if (clr) begin
                good_m = '0;
                bad_m  = '0;
            end
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_one_cycle got=%b exp=0", done); end
            checks++; if (crc_ok !== exp_ok) begin failures++; $display("FAIL crc_ok_held got=%b exp=%b", crc_ok, exp_ok); end
            checks++; if (good_cnt !== good_m) begin failures++; $display("FAIL good_cnt got=%0d exp=%0d", good_cnt, good_m); end
            checks++; if (bad_cnt !== bad_m) begin failures++; $display("FAIL bad_cnt got=%0d exp=%0d", bad_cnt, bad_m); end
        end
    endtask

    task automatic test_reset();
        bus.s_valid_i = 1'b0; bus.s_data_i = '0; bus.s_last_i = 1'b0; bus.s_nbytes_i = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (done !== 1'b0 || crc_ok !== 1'b0 || runt !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b%b exp=000", done, crc_ok, runt); end
        checks++; if (crc !== 32'h0 || len !== 16'h0) begin failures++; $display("FAIL reset_crc_len got=%h/%0d exp=0/0", crc, len); end
        checks++; if (good_cnt !== 16'h0 || bad_cnt !== 16'h0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", good_cnt, bad_cnt); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.s_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.s_ready_o); end
    endtask

    task automatic test_known_vector();
        frame_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                    8'h26, 8'h39, 8'hF4, 8'hCB};
        send_frame(1'b0, 1'b0, 1'b0);
        checks++; if (crc !== 32'h2144_DF1C) begin failures++; $display("FAIL vec_crc got=%h exp=2144df1c", crc); end
        checks++; if (crc_ok !== 1'b1 || len !== 16'd13) begin failures++; $display("FAIL vec_ok_len got=%b/%0d exp=1/13", crc_ok, len); end
        checks++; if (good_cnt !== 16'd1) begin failures++; $display("FAIL vec_good got=%0d exp=1", good_cnt); end
    endtask

    task automatic test_no_fcs();
        frame_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        send_frame(1'b0, 1'b0, 1'b0);
        checks++; if (crc !== 32'hCBF4_3926 || len !== 16'd9) begin failures++; $display("FAIL nofcs_crc got=%h/%0d exp=cbf43926/9", crc, len); end
        checks++; if (crc_ok !== 1'b0 || bad_cnt !== 16'd1) begin failures++; $display("FAIL nofcs_bad got=%b/%0d exp=0/1", crc_ok, bad_cnt); end
    endtask

    task automatic test_bit_flip();
        logic [15:0] good_before;
        good_before = good_cnt;
        random_payload(10);
        append_fcs();
        frame_q[5][0] = ~frame_q[5][0];
        send_frame(1'b0, 1'b0, 1'b1);
        checks++; if (crc_ok !== 1'b0 || good_cnt !== good_before) begin failures++; $display("FAIL flip got=%b/%0d exp=0/%0d", crc_ok, good_cnt, good_before); end
    endtask

    task automatic test_runt_and_min_len();
        random_payload(2);
        send_frame(1'b0, 1'b0, 1'b0);
        checks++; if (runt !== 1'b1 || len !== 16'd2) begin failures++; $display("FAIL runt2 got=%b/%0d exp=1/2", runt, len); end
        // Empty payload plus its FCS is exactly MIN_LEN and valid.
        frame_q.delete();
        append_fcs();
        send_frame(1'b0, 1'b0, 1'b0);
        checks++; if (runt !== 1'b0 || crc_ok !== 1'b1) begin failures++; $display("FAIL minlen got=%b/%b exp=0/1", runt, crc_ok); end
        random_payload(3);
        send_frame(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_clear();
        random_payload(7);
        append_fcs();
        send_frame(1'b0, 1'b1, 1'b0);
        checks++; if (good_cnt !== 16'd0 || bad_cnt !== 16'd0) begin failures++; $display("FAIL clear got=%0d/%0d exp=0/0", good_cnt, bad_cnt); end
    endtask

    task automatic test_back_to_back();
        random_payload(8);
        append_fcs();
        send_frame(1'b1, 1'b0, 1'b0);
        random_payload(5);
        append_fcs();
        send_frame(1'b0, 1'b0, 1'b0);
        checks++; if (good_cnt !== 16'd2) begin failures++; $display("FAIL b2b_good got=%0d exp=2", good_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 2; i++) begin
            bus.s_valid_i  = 1'b1;
            bus.s_data_i   = 24'($urandom());
            bus.s_last_i   = 1'b0;
            bus.s_nbytes_i = 2'd3;
            @(posedge clk);
            @(negedge clk);
        end
        bus.s_valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (good_cnt !== 16'd0 || crc !== 32'h0 || len !== 16'h0) begin failures++; $display("FAIL midrst_out got=%0d/%h/%0d exp=0/0/0", good_cnt, crc, len); end
        @(negedge clk);
        rst_n = 1'b1;
        good_m = '0;
        bad_m  = '0;
        in_report = 1'b0;
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", done); end
        random_payload(11);
        append_fcs();
        send_frame(1'b0, 1'b0, 1'b0);
        checks++; if (crc_ok !== 1'b1) begin failures++; $display("FAIL midrst_next got=%b exp=1", crc_ok); end
    endtask

    task automatic test_random();
        int kind;
        for (int f = 0; f < 30; f++) begin
            kind = $urandom_range(0, 3);
            random_payload($urandom_range(0, 20));
            if (kind != 0) append_fcs();
            if (kind == 3) begin
                int pos;
                pos = $urandom_range(0, frame_q.size() - 1);
                frame_q[pos][$urandom_range(0, 7)] ^= 1'b1;
            end
            if (frame_q.size() == 0) frame_q.push_back(8'($urandom()));
            send_frame($urandom_range(0, 2) == 0 && f != 29, 1'b0, 1'b1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_known_vector();
        test_no_fcs();
        test_bit_flip();
        test_runt_and_min_len();
        test_clear();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
